// File: rtl/idma_eh_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : idma_eh_sequencer
// Brief    : iDMA backend error-handling controller. Arbitrates read, write and
//            backend errors, reports them one at a time and applies the
//            frontend's CONTINUE/ABORT action. Optional error capture FIFO is
//            enabled with `define IDMA_EH_ERR_FIFO_EN.
// Revision : 1.0 - initial release
// ============================================================================
module idma_eh_sequencer #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned ERR_FIFO_DEPTH = 2,
    parameter int unsigned CNT_WIDTH      = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  r_err_valid_i,
    input  logic [ADDR_WIDTH-1:0] r_err_addr_i,
    output logic                  r_err_ready_o,
    input  logic                  w_err_valid_i,
    input  logic [ADDR_WIDTH-1:0] w_err_addr_i,
    output logic                  w_err_ready_o,
    input  logic                  be_err_valid_i,
    input  logic [ADDR_WIDTH-1:0] be_err_addr_i,
    output logic                  be_err_ready_o,
    output logic                  err_valid_o,
    input  logic                  err_ready_i,
    output logic [1:0]            err_type_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    input  logic                  eh_valid_i,
    input  logic                  eh_i,
    output logic                  eh_ready_o,
    output logic                  halt_o,
    output logic                  abort_o,
    input  logic                  abort_done_i,
    output logic [CNT_WIDTH-1:0]  abort_cnt_o,
    output logic                  eh_fsm_busy_o,
    output logic                  eh_cnt_busy_o
);

    localparam logic [1:0] c_ST_IDLE     = 2'd0;
    localparam logic [1:0] c_ST_REPORT   = 2'd1;
    localparam logic [1:0] c_ST_WAIT_ACT = 2'd2;
    localparam logic [1:0] c_ST_ABORT    = 2'd3;

    localparam logic [1:0] c_TYPE_RD = 2'd0;
    localparam logic [1:0] c_TYPE_WR = 2'd1;
    localparam logic [1:0] c_TYPE_BE = 2'd2;

    // Pending holds every FIFO entry plus the error currently being handled.
    localparam int unsigned c_PEND_W = $clog2(ERR_FIFO_DEPTH + 2);

    logic [1:0]            r_state;
    logic [1:0]            r_cap_type;
    logic [ADDR_WIDTH-1:0] r_cap_addr;
    logic [c_PEND_W-1:0]   r_pend;
    logic [CNT_WIDTH-1:0]  r_abort_cnt;

    logic                  w_src_any;
    logic [1:0]            w_src_type;
    logic [ADDR_WIDTH-1:0] w_src_addr;
    logic                  w_push;
    logic                  w_grant;
    logic                  w_take;
    logic [1:0]            w_take_type;
    logic [ADDR_WIDTH-1:0] w_take_addr;
    logic                  w_resolve;

    // Fixed priority: BACKEND > BUS_READ > BUS_WRITE.
    always_comb begin
        w_src_any  = be_err_valid_i | r_err_valid_i | w_err_valid_i;
        w_src_type = c_TYPE_WR;
        w_src_addr = w_err_addr_i;
        if (be_err_valid_i) begin
            w_src_type = c_TYPE_BE;
            w_src_addr = be_err_addr_i;
        end else if (r_err_valid_i) begin
            w_src_type = c_TYPE_RD;
            w_src_addr = r_err_addr_i;
        end
    end

`ifdef IDMA_EH_ERR_FIFO_EN
    localparam int unsigned c_PTR_W = $clog2(ERR_FIFO_DEPTH);

    logic [1:0]            r_fifo_type [ERR_FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0] r_fifo_addr [ERR_FIFO_DEPTH];
    logic [c_PTR_W:0]      r_wr_ptr;
    logic [c_PTR_W:0]      r_rd_ptr;
    logic                  w_fifo_empty;
    logic                  w_fifo_full;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_fifo_full  = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                          (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign w_take       = (r_state == c_ST_IDLE) && !w_fifo_empty;
    // A pop in the same cycle frees the slot, so a full FIFO may still accept.
    assign w_push       = w_src_any && (!w_fifo_full || w_take);
    assign w_take_type  = r_fifo_type[r_rd_ptr[c_PTR_W-1:0]];
    assign w_take_addr  = r_fifo_addr[r_rd_ptr[c_PTR_W-1:0]];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            for (int i = 0; i < int'(ERR_FIFO_DEPTH); i++) begin
                r_fifo_type[i] <= '0;
                r_fifo_addr[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_fifo_type[r_wr_ptr[c_PTR_W-1:0]] <= w_src_type;
                r_fifo_addr[r_wr_ptr[c_PTR_W-1:0]] <= w_src_addr;
                r_wr_ptr <= r_wr_ptr + (c_PTR_W+1)'(1);
            end
            if (w_take) begin
                r_rd_ptr <= r_rd_ptr + (c_PTR_W+1)'(1);
            end
        end
    end
`else
    assign w_push      = (r_state == c_ST_IDLE) && w_src_any;
    assign w_take      = w_push;
    assign w_take_type = w_src_type;
    assign w_take_addr = w_src_addr;
`endif

    assign w_grant        = w_push && !rst_i;
    assign be_err_ready_o = w_grant && be_err_valid_i;
    assign r_err_ready_o  = w_grant && r_err_valid_i && !be_err_valid_i;
    assign w_err_ready_o  = w_grant && w_err_valid_i && !be_err_valid_i && !r_err_valid_i;

    assign w_resolve = ((r_state == c_ST_WAIT_ACT) && eh_valid_i && !eh_i) ||
                       ((r_state == c_ST_ABORT) && abort_done_i);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state     <= c_ST_IDLE;
            r_cap_type  <= '0;
            r_cap_addr  <= '0;
            r_pend      <= '0;
            r_abort_cnt <= '0;
        end else begin
            if (w_take) begin
                r_cap_type <= w_take_type;
                r_cap_addr <= w_take_addr;
            end
            case (r_state)
                c_ST_IDLE: begin
                    if (w_take) r_state <= c_ST_REPORT;
                end
                c_ST_REPORT: begin
                    if (err_ready_i) r_state <= c_ST_WAIT_ACT;
                end
                c_ST_WAIT_ACT: begin
                    if (eh_valid_i) begin
                        if (eh_i) begin
                            r_state <= c_ST_ABORT;
                            if (!(&r_abort_cnt)) r_abort_cnt <= r_abort_cnt + CNT_WIDTH'(1);
                        end else begin
                            r_state <= c_ST_IDLE;
                        end
                    end
                end
                default: begin
                    if (abort_done_i) r_state <= c_ST_IDLE;
                end
            endcase
            case ({w_push, w_resolve})
                2'b10:   r_pend <= r_pend + c_PEND_W'(1);
                2'b01:   r_pend <= r_pend - c_PEND_W'(1);
                default: r_pend <= r_pend;
            endcase
        end
    end

    assign err_valid_o   = (r_state == c_ST_REPORT);
    assign err_type_o    = r_cap_type;
    assign err_addr_o    = r_cap_addr;
    assign eh_ready_o    = (r_state == c_ST_WAIT_ACT);
    assign halt_o        = (r_state != c_ST_IDLE);
    assign abort_o       = (r_state == c_ST_ABORT);
    assign abort_cnt_o   = r_abort_cnt;
    assign eh_fsm_busy_o = (r_state != c_ST_IDLE);
    assign eh_cnt_busy_o = (r_pend != '0);

endmodule
`default_nettype wire

// File: doc/idma_eh_sequencer.md
Name: idma_eh_sequencer

Overview:
- Central error-handling controller for the iDMA backend.
- Collects error events from the read leg, the write leg and the backend length check, and arbitrates them.
- Presents one error at a time to the frontend, then applies the returned action (CONTINUE or ABORT) by halting or aborting the legs.
- Drives the eh_fsm_busy and eh_cnt_busy fields of the backend busy vector.

Parameters:
- AddrWidth, 32, width of the faulting address reported per error.
- ErrFifoDepth, 2, error capture FIFO entries (power of two, ≥2); used only with the optional feature.
- CntWidth, 8, width of the saturating abort counter.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- r_err_valid_i  in  1  read-leg bus error
- r_err_addr_i  in  AddrWidth  read-leg faulting address
- r_err_ready_o  out  1  read-leg error accepted
- w_err_valid_i  in  1  write-leg bus error
- w_err_addr_i  in  AddrWidth  write-leg faulting address
- w_err_ready_o  out  1  write-leg error accepted
- be_err_valid_i  in  1  backend error (zero-length transfer)
- be_err_addr_i  in  AddrWidth  backend source address
- be_err_ready_o  out  1  backend error accepted
- err_valid_o  out  1  error report valid to frontend
- err_ready_i  in  1  frontend accepts report
- err_type_o  out  2  0 BUS_READ, 1 BUS_WRITE, 2 BACKEND
- err_addr_o  out  AddrWidth  reported address
- eh_valid_i  in  1  action valid
- eh_i  in  1  0 CONTINUE, 1 ABORT
- eh_ready_o  out  1  action accepted
- halt_o  out  1  legs stall
- abort_o  out  1  legs abort current 1D transfer
- abort_done_i  in  1  legs have flushed
- abort_cnt_o  out  CntWidth  saturating count of ABORT actions
- eh_fsm_busy_o  out  1  FSM not IDLE
- eh_cnt_busy_o  out  1  errors pending (captured but not yet resolved)

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; abort_cnt_o 0; capture registers cleared.
- Arbitration: fixed priority BACKEND > BUS_READ > BUS_WRITE. The source `*_ready_o` is combinational. Exactly one source is granted per cycle.
- FSM states: IDLE, REPORT, WAIT_ACT, ABORT.
- IDLE:
  - If an error is available, the winner is captured (type, addr) and its ready_o=1 that cycle.
  - Next cycle: REPORT.
- REPORT:
  - err_valid_o=1; err_type_o/err_addr_o come from the capture registers and are stable while valid.
  - On err_ready_i: WAIT_ACT.
- WAIT_ACT:
  - eh_ready_o=1.
  - On eh_valid_i with CONTINUE: IDLE.
  - On eh_valid_i with ABORT: ABORT, and abort_cnt_o increments (saturates at all-ones).
- ABORT:
  - abort_o=1, held until abort_done_i.
  - Then IDLE the following cycle.
  - abort_done_i is ignored in every other state.
- halt_o=1 in REPORT, WAIT_ACT and ABORT. It deasserts on the cycle the FSM is in IDLE.
- Latency: source handshake to err_valid_o is 1 cycle. eh handshake to halt_o low (CONTINUE) is 1 cycle.
- Back-to-back: a new error can be granted in the first IDLE cycle after resolution. No idle bubble is required beyond that cycle.
- eh_fsm_busy_o = (state != IDLE).
- eh_cnt_busy_o = (pending count != 0). Pending counts captured errors (FIFO entries plus the current error), decrementing on resolution.
- Without FIFO: the source ready is asserted only in IDLE; sources stall while an error is handled.
- Reset mid-operation: immediate return to IDLE; halt_o/abort_o drop asynchronously; pending count and FIFO cleared.

Optional Feature:
- Macro: IDMA_EH_ERR_FIFO_EN.
- Defined:
  - Arbitrated errors are pushed into an ErrFifoDepth-entry FIFO. Sources are accepted in any state while the FIFO is not full; when full, all source readies are 0.
  - IDLE pops the FIFO head; IDLE→REPORT is still 1 cycle after the pop.
  - Push and pop in the same cycle are allowed when full.
- Undefined: no FIFO; capture direct in IDLE as above.

Test Plan:
- r_err_valid_i=1, addr 0x1000, frontend err_ready_i=1 then eh_i=CONTINUE:
  - r_err_ready_o pulses once.
  - err_valid_o, type 0, addr 0x1000, one cycle later.
  - halt_o low 1 cycle after the eh handshake; abort_cnt_o stays 0.
- be_err and w_err both valid in the same cycle:
  - BACKEND is reported first (type 2).
  - After CONTINUE, BUS_WRITE (type 1) is reported.
- ABORT action, abort_done_i asserted 5 cycles later:
  - abort_o high exactly 5 cycles; IDLE the next cycle; abort_cnt_o=1.
- 256 consecutive ABORTs (CntWidth=8): abort_cnt_o saturates at 0xFF.
- With IDMA_EH_ERR_FIFO_EN and ErrFifoDepth=2, three read errors while the FSM is in REPORT:
  - First two accepted, third stalled with ready 0.
  - eh_cnt_busy_o stays high until all resolved, with reports in order.
- rst_i asserted while in ABORT with a pending FIFO entry:
  - All outputs 0, eh_cnt_busy_o 0.
  - Next error after release is reported fresh with no stale entry.
